// File: rtl/wb_commit_if.sv
// MEM/WB pipeline-register bundle consumed by the write-back commit stage.
// The master modport drives the bundle; the commit stage takes the slave side.
interface wb_commit_if;
   logic [31:0] wr_dout;
   logic [31:0] wr_result;
   logic [31:0] wr_HL;
   logic [63:0] wr_mult;
   logic [31:0] wr_busA_mux2;
   logic [31:0] wr_busB_mux2;
   logic [31:0] wr_cp0_dout;
   logic [31:0] wr_pc;
   logic [4:0]  wr_rw;
   logic [4:0]  wr_cs;
   logic [2:0]  wr_sel;
   logic [5:0]  wr_op;
   logic [1:0]  wr_memtoreg;
   logic [2:0]  wr_cp0op;
   logic        wr_regWr;
   logic        wr_multWr;
   logic        wr_Highin;
   logic        wr_Lowin;

   modport master (
      output wr_dout, wr_result, wr_HL, wr_mult, wr_busA_mux2, wr_busB_mux2,
             wr_cp0_dout, wr_pc, wr_rw, wr_cs, wr_sel, wr_op, wr_memtoreg,
             wr_cp0op, wr_regWr, wr_multWr, wr_Highin, wr_Lowin
   );

   modport slave (
      input  wr_dout, wr_result, wr_HL, wr_mult, wr_busA_mux2, wr_busB_mux2,
             wr_cp0_dout, wr_pc, wr_rw, wr_cs, wr_sel, wr_op, wr_memtoreg,
             wr_cp0op, wr_regWr, wr_multWr, wr_Highin, wr_Lowin
   );
endinterface

// File: rtl/wb_commit.sv
// Write-back commit stage: GPR write port with load extraction, HI/LO, CP0 Status/Cause/EPC.
// Define WB_COUNT_EN to add the free-running CP0 Count register (cs 9).
module wb_commit #(
   parameter logic [31:0] STATUS_RST   = 32'h0000_FF00,
   parameter logic [4:0]  SYSCALL_CODE = 5'd8
) (
   input  logic         clk,
   input  logic         rst,
   wb_commit_if.slave   wr,
   input  logic [4:0]   cp0_rcs,
   output logic         rf_we,
   output logic [4:0]   rf_waddr,
   output logic [31:0]  rf_wdata,
   output logic [31:0]  hi,
   output logic [31:0]  lo,
   output logic [31:0]  hi_byp,
   output logic [31:0]  lo_byp,
   output logic [31:0]  cp0_rdata,
   output logic [31:0]  epc_out,
   output logic         exl
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   localparam logic [2:0] CP0_MTC0    = 3'b010;
   localparam logic [2:0] CP0_ERET    = 3'b011;
   localparam logic [2:0] CP0_SYSCALL = 3'b100;

   localparam logic [4:0] CS_COUNT  = 5'd9;
   localparam logic [4:0] CS_STATUS = 5'd12;
   localparam logic [4:0] CS_CAUSE  = 5'd13;
   localparam logic [4:0] CS_EPC    = 5'd14;

   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] status_q, status_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic        mtc0_en;
   logic [1:0]  byte_a;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign mtc0_en = ~rst & (wr.wr_cp0op == CP0_MTC0) & (wr.wr_sel == 3'd0);

   // GPR write port
   assign rf_we    = ~rst & wr.wr_regWr & (wr.wr_rw != 5'd0);
   assign rf_waddr = wr.wr_rw;

   assign byte_a  = wr.wr_result[1:0];
   assign ld_byte = 8'(wr.wr_dout >> {byte_a, 3'b000});
   assign ld_half = byte_a[1] ? wr.wr_dout[31:16] : wr.wr_dout[15:0];

   always_comb begin
      ld_data = wr.wr_dout;
      case (wr.wr_op)
         OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  ld_data = {24'd0, ld_byte};
         OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  ld_data = {16'd0, ld_half};
         OP_LW:   ld_data = wr.wr_dout;
         default: ld_data = wr.wr_dout;
      endcase
   end

   always_comb begin
      rf_wdata = wr.wr_result;
      case (wr.wr_memtoreg)
         2'd0: rf_wdata = wr.wr_result;
         2'd1: rf_wdata = ld_data;
         2'd2: rf_wdata = wr.wr_HL;
         2'd3: rf_wdata = wr.wr_cp0_dout;
         default: rf_wdata = wr.wr_result;
      endcase
   end

   // HI/LO next state doubles as the forwarding value, so it also reflects reset.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (rst) begin
         hi_d = '0;
         lo_d = '0;
      end else if (wr.wr_multWr) begin
         hi_d = wr.wr_mult[63:32];
         lo_d = wr.wr_mult[31:0];
      end else begin
         if (wr.wr_Highin) hi_d = wr.wr_busA_mux2;
         if (wr.wr_Lowin)  lo_d = wr.wr_busA_mux2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi     = hi_q;
   assign lo     = lo_q;
   assign hi_byp = hi_d;
   assign lo_byp = lo_d;

   always_comb begin
      status_d = status_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      if (!rst) begin
         case (wr.wr_cp0op)
            CP0_MTC0: begin
               if (wr.wr_sel == 3'd0) begin
                  case (wr.wr_cs)
                     CS_STATUS: status_d = wr.wr_busB_mux2;
                     CS_CAUSE:  cause_d[9:8] = wr.wr_busB_mux2[9:8];
                     CS_EPC:    epc_d = wr.wr_busB_mux2;
                     default:   ;
                  endcase
               end
            end
            CP0_ERET: status_d[1] = 1'b0;
            CP0_SYSCALL: begin
               epc_d        = wr.wr_pc;
               cause_d[6:2] = SYSCALL_CODE;
               status_d[1]  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= STATUS_RST;
         cause_q  <= '0;
         epc_q    <= '0;
      end else begin
         status_q <= status_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
      end
   end

`ifdef WB_COUNT_EN
   logic [31:0] count_q, count_d;

   // A committing mtc0 to Count wins over that cycle's increment.
   always_comb begin
      count_d = count_q + 32'd1;
      if (mtc0_en && (wr.wr_cs == CS_COUNT)) count_d = wr.wr_busB_mux2;
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end
`endif

   always_comb begin
      cp0_rdata = '0;
      case (cp0_rcs)
         CS_STATUS: cp0_rdata = status_q;
         CS_CAUSE:  cp0_rdata = cause_q;
         CS_EPC:    cp0_rdata = epc_q;
`ifdef WB_COUNT_EN
         CS_COUNT:  cp0_rdata = count_q;
`endif
         default:   cp0_rdata = '0;
      endcase
      // Same-cycle mtc0 to the register being read in MEM is forwarded.
      if (mtc0_en && (wr.wr_cs == cp0_rcs)) begin
         case (cp0_rcs)
            CS_STATUS: cp0_rdata = wr.wr_busB_mux2;
            CS_CAUSE:  cp0_rdata = {cause_q[31:10], wr.wr_busB_mux2[9:8], cause_q[7:0]};
            CS_EPC:    cp0_rdata = wr.wr_busB_mux2;
`ifdef WB_COUNT_EN
            CS_COUNT:  cp0_rdata = wr.wr_busB_mux2;
`endif
            default:   ;
         endcase
      end
   end

   assign epc_out = epc_q;
   assign exl     = status_q[1];

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: load extraction, result select, HI/LO, CP0 and optional Count.
module tb_wb_commit;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  cp0_rcs;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, hi, lo, hi_byp, lo_byp, cp0_rdata, epc_out;
   logic        exl;

   int vecs = 0;
   int errs = 0;

   wb_commit_if wb();

   wb_commit dut (
      .clk(clk), .rst(rst), .wr(wb), .cp0_rcs(cp0_rcs),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .hi(hi), .lo(lo), .hi_byp(hi_byp), .lo_byp(lo_byp),
      .cp0_rdata(cp0_rdata), .epc_out(epc_out), .exl(exl)
   );

   always #5 clk = ~clk;

   task automatic idle();
      wb.wr_dout = '0; wb.wr_result = '0; wb.wr_HL = '0; wb.wr_mult = '0;
      wb.wr_busA_mux2 = '0; wb.wr_busB_mux2 = '0; wb.wr_cp0_dout = '0; wb.wr_pc = '0;
      wb.wr_rw = '0; wb.wr_cs = '0; wb.wr_sel = '0; wb.wr_op = '0; wb.wr_memtoreg = '0;
      wb.wr_cp0op = '0; wb.wr_regWr = 0; wb.wr_multWr = 0; wb.wr_Highin = 0; wb.wr_Lowin = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      idle(); cp0_rcs = 5'd12; rst = 1'b1;
      wb.wr_multWr = 1; wb.wr_mult = 64'hDEAD_BEEF_1234_5678; wb.wr_regWr = 1; wb.wr_rw = 5'd4;
      #1;
      vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL rst_rf_we: got %b expected 0", rf_we); end
      step(); step();
      rst = 1'b0; idle(); #1;
      vecs++; if (hi !== 32'd0 || lo !== 32'd0) begin errs++; $display("FAIL rst_hilo: got %h/%h expected 0/0", hi, lo); end
      vecs++; if (cp0_rdata !== 32'h0000_FF00) begin errs++; $display("FAIL rst_status: got %h expected 0000ff00", cp0_rdata); end
      cp0_rcs = 5'd13; #1;
      vecs++; if (cp0_rdata !== 32'd0) begin errs++; $display("FAIL rst_cause: got %h expected 0", cp0_rdata); end
      vecs++; if (epc_out !== 32'd0 || exl !== 1'b0) begin errs++; $display("FAIL rst_epc_exl: got %h/%b expected 0/0", epc_out, exl); end
   endtask

   task automatic test_load();
      logic [5:0]  ops  [7] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h0F, 6'h20};
      logic [31:0] addr [7] = '{32'h1001, 32'h1001, 32'h1002, 32'h1002, 32'h1000, 32'h1000, 32'h1003};
      logic [31:0] dout [7] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000, 32'h8001_0000,
                               32'hCAFE_F00D, 32'h1234_5678, 32'h7F00_0000};
      logic [31:0] exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                               32'hCAFE_F00D, 32'h1234_5678, 32'h0000_007F};
      idle(); wb.wr_memtoreg = 2'd1; wb.wr_regWr = 1; wb.wr_rw = 5'd3;
      for (int i = 0; i < 7; i++) begin
         wb.wr_op = ops[i]; wb.wr_result = addr[i]; wb.wr_dout = dout[i];
         #1;
         vecs++;
         if (rf_wdata !== exp[i] || rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            errs++;
            $display("FAIL load[%0d]: got we=%b a=%0d d=%h expected we=1 a=3 d=%h", i, rf_we, rf_waddr, rf_wdata, exp[i]);
         end
      end
   endtask

   task automatic test_select();
      idle(); wb.wr_regWr = 1; wb.wr_rw = 5'd7;
      wb.wr_result = 32'h1111_1111; wb.wr_HL = 32'h2222_2222; wb.wr_cp0_dout = 32'h3333_3333;
      wb.wr_memtoreg = 2'd0; #1; chk32("sel_result", rf_wdata, 32'h1111_1111);
      wb.wr_memtoreg = 2'd2; #1; chk32("sel_hl", rf_wdata, 32'h2222_2222);
      wb.wr_memtoreg = 2'd3; #1; chk32("sel_cp0", rf_wdata, 32'h3333_3333);
      wb.wr_memtoreg = 2'd0; wb.wr_rw = 5'd0; wb.wr_result = 32'd5; #1;
      vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL r0_we: got %b expected 0", rf_we); end
      wb.wr_rw = 5'd31; wb.wr_regWr = 0; #1;
      vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL nowr_we: got %b expected 0", rf_we); end
   endtask

   task automatic test_hilo();
      idle(); wb.wr_multWr = 1; wb.wr_mult = 64'h0000_0001_0000_0002; wb.wr_Lowin = 1; wb.wr_busA_mux2 = 32'd7;
      #1;
      chk32("mult_lo_byp", lo_byp, 32'd2);
      chk32("mult_hi_byp", hi_byp, 32'd1);
      step(); idle(); #1;
      chk32("mult_hi", hi, 32'd1);
      chk32("mult_lo", lo, 32'd2);
      chk32("idle_lo_byp", lo_byp, 32'd2);
      wb.wr_Highin = 1; wb.wr_busA_mux2 = 32'hAAAA_5555; #1;
      chk32("mthi_hi_byp", hi_byp, 32'hAAAA_5555);
      chk32("mthi_lo_byp", lo_byp, 32'd2);
      step(); idle(); #1;
      chk32("mthi_hi", hi, 32'hAAAA_5555);
      wb.wr_Highin = 1; wb.wr_Lowin = 1; wb.wr_busA_mux2 = 32'h0000_0005;
      step(); idle(); #1;
      vecs++; if (hi !== 32'd5 || lo !== 32'd5) begin errs++; $display("FAIL mthilo_both: got %h/%h expected 5/5", hi, lo); end
   endtask

   task automatic test_cp0();
      idle(); cp0_rcs = 5'd13;
      wb.wr_cp0op = 3'b010; wb.wr_cs = 5'd13; wb.wr_busB_mux2 = 32'hFFFF_FFFF; #1;
      chk32("cause_bypass", cp0_rdata, 32'h0000_0300);
      step(); idle(); #1;
      chk32("cause_mtc0", cp0_rdata, 32'h0000_0300);
      wb.wr_cp0op = 3'b100; wb.wr_pc = 32'h0040_0010;
      step(); idle(); #1;
      chk32("sys_epc", epc_out, 32'h0040_0010);
      chk32("sys_cause", cp0_rdata, 32'h0000_0320);
      vecs++; if (exl !== 1'b1) begin errs++; $display("FAIL sys_exl: got %b expected 1", exl); end
      cp0_rcs = 5'd12; #1;
      chk32("sys_status", cp0_rdata, 32'h0000_FF02);
      wb.wr_cp0op = 3'b011;
      step(); idle(); #1;
      vecs++; if (exl !== 1'b0) begin errs++; $display("FAIL eret_exl: got %b expected 0", exl); end
      chk32("eret_epc", epc_out, 32'h0040_0010);
      wb.wr_cp0op = 3'b010; wb.wr_cs = 5'd14; wb.wr_sel = 3'd1; wb.wr_busB_mux2 = 32'h1234_0000;
      step(); idle(); #1;
      chk32("sel1_ignored", epc_out, 32'h0040_0010);
      cp0_rcs = 5'd14; wb.wr_cp0op = 3'b010; wb.wr_cs = 5'd14; wb.wr_busB_mux2 = 32'hBFC0_0380; #1;
      chk32("epc_bypass", cp0_rdata, 32'hBFC0_0380);
      step(); idle(); #1;
      chk32("epc_mtc0", epc_out, 32'hBFC0_0380);
      cp0_rcs = 5'd12; wb.wr_cp0op = 3'b001; wb.wr_cs = 5'd12; wb.wr_busB_mux2 = 32'h0;
      step(); idle(); #1;
      chk32("mfc0_nochange", cp0_rdata, 32'h0000_FF00);
      cp0_rcs = 5'd5; wb.wr_cp0op = 3'b010; wb.wr_cs = 5'd5; wb.wr_busB_mux2 = 32'h5555_5555; #1;
      chk32("cs5_reads0", cp0_rdata, 32'd0);
      idle();
`ifndef WB_COUNT_EN
      cp0_rcs = 5'd9; wb.wr_cp0op = 3'b010; wb.wr_cs = 5'd9; wb.wr_busB_mux2 = 32'h5555_5555; #1;
      chk32("cs9_absent_byp", cp0_rdata, 32'd0);
      step(); idle(); #1;
      chk32("cs9_absent", cp0_rdata, 32'd0);
`endif
   endtask

   task automatic test_parallel();
      idle(); cp0_rcs = 5'd12;
      wb.wr_regWr = 1; wb.wr_rw = 5'd9; wb.wr_result = 32'hABCD_0123;
      wb.wr_multWr = 1; wb.wr_mult = 64'h0000_0033_0000_0044; wb.wr_Highin = 1; wb.wr_busA_mux2 = 32'h99;
      wb.wr_cp0op = 3'b010; wb.wr_cs = 5'd12; wb.wr_busB_mux2 = 32'h1234_5602; #1;
      vecs++;
      if (rf_we !== 1'b1 || rf_wdata !== 32'hABCD_0123 || hi_byp !== 32'h33 || cp0_rdata !== 32'h1234_5602) begin
         errs++;
         $display("FAIL par_comb: got we=%b d=%h hb=%h cp0=%h expected 1 abcd0123 33 12345602", rf_we, rf_wdata, hi_byp, cp0_rdata);
      end
      step(); idle(); #1;
      vecs++;
      if (hi !== 32'h33 || lo !== 32'h44 || cp0_rdata !== 32'h1234_5602 || exl !== 1'b1) begin
         errs++;
         $display("FAIL par_state: got %h %h %h %b expected 33 44 12345602 1", hi, lo, cp0_rdata, exl);
      end
   endtask

   task automatic test_midrun_reset();
      idle(); rst = 1'b1; wb.wr_Highin = 1; wb.wr_busA_mux2 = 32'hFFFF_0000;
      wb.wr_cp0op = 3'b100; wb.wr_pc = 32'h8000_0000;
      step(); rst = 1'b0; idle(); cp0_rcs = 5'd12; #1;
      vecs++;
      if (hi !== 32'd0 || lo !== 32'd0 || epc_out !== 32'd0 || exl !== 1'b0 || cp0_rdata !== 32'h0000_FF00) begin
         errs++;
         $display("FAIL midrun_rst: got %h %h %h %b %h expected 0 0 0 0 0000ff00", hi, lo, epc_out, exl, cp0_rdata);
      end
   endtask

`ifdef WB_COUNT_EN
   task automatic test_count();
      idle(); cp0_rcs = 5'd9; rst = 1'b1;
      step(); rst = 1'b0; #1;
      chk32("count_rst", cp0_rdata, 32'd0);
      repeat (5) step();
      chk32("count_5", cp0_rdata, 32'd5);
      wb.wr_cp0op = 3'b010; wb.wr_cs = 5'd9; wb.wr_busB_mux2 = 32'hFFFF_FFFF; #1;
      chk32("count_byp", cp0_rdata, 32'hFFFF_FFFF);
      step(); idle(); #1;
      chk32("count_load", cp0_rdata, 32'hFFFF_FFFF);
      step();
      chk32("count_wrap", cp0_rdata, 32'd0);
      step(); step();
      rst = 1'b1; step(); rst = 1'b0; #1;
      chk32("count_midrst", cp0_rdata, 32'd0);
   endtask
`endif

   initial begin
      rst = 1'b1; cp0_rcs = '0; idle();
      test_reset();
      test_load();
      test_select();
      test_hilo();
      test_cp0();
      test_parallel();
      test_midrun_reset();
`ifdef WB_COUNT_EN
      test_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
